seq_shifter: RTL and testbench
==============================

# seq_shifter

Multi-cycle, parametrised shift/rotate unit implementing ARM register-specified shift semantics for LSL, LSR, ASR and ROR, including the shifter carry-out. It sits beside the ALU in the datapath and serves DP instructions whose Operand2 is shifted by a register amount (`sh` = Instr[6:5], amount = Rs[7:0]). The unit uses a valid/ready handshake on both sides, so the controller can stall while a shift is in flight. STEP trades latency against area.

## Interface
- WIDTH, 32, operand/result width
- SHAMT_W, 8, shift-amount width; must satisfy SHAMT_W ≥ clog2(WIDTH+2)
- STEP, 1, bits shifted per cycle; power of two, 1 ≤ STEP ≤ WIDTH
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request (high only in IDLE)
- a  in  WIDTH  operand
- shamt  in  SHAMT_W  shift amount (unsigned)
- sh  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
- carry_in  in  1  current CPSR C flag
- out_valid  out  1  result valid (high only in DONE)
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  shifted value
- carry_out  out  1  shifter carry-out
- busy  out  1  high in SHIFT or DONE

## Operation
- FSM states: IDLE, SHIFT, DONE.
- Accept occurs on the edge where in_valid & in_ready. At accept, the unit latches the operand into a working register, latches carry_in into the carry register, and loads the remaining count cnt (clog2(WIDTH+2) bits) as follows:
  - shamt = 0: cnt = 0, for all modes.
  - LSL or LSR: cnt = min(shamt, WIDTH+1).
  - ASR: cnt = min(shamt, WIDTH).
  - ROR: m = shamt mod WIDTH; cnt = (m = 0) ? WIDTH : m.
- Transitions:
  - IDLE → DONE on accept when cnt = 0.
  - IDLE → SHIFT on accept when cnt > 0.
  - SHIFT → DONE on the step edge that brings cnt to 0.
  - DONE → IDLE on out_ready.
- Each SHIFT cycle shifts by s = min(STEP, cnt) and then sets cnt -= s. The carry register takes the last bit shifted out in that step:
  - LSL: shift left with zero fill; carry = bit WIDTH−s of the pre-step value.
  - LSR: shift right with zero fill; carry = bit s−1.
  - ASR: shift right with sign fill; carry = bit s−1.
  - ROR: rotate right; carry = bit s−1.
- The cnt clamps above reproduce ARM semantics without special cases:
  - LSL/LSR by exactly WIDTH: result 0, carry = a[0] (LSL) or a[WIDTH−1] (LSR).
  - LSL/LSR by more than WIDTH: result 0, carry 0.
  - ASR by WIDTH or more: result all sign bits, carry = sign.
  - ROR by a nonzero multiple of WIDTH: result = a, carry = a[WIDTH−1].
  - shamt = 0: result = a, carry = carry_in.
- result and carry_out drive directly from the working and carry registers.
- Inputs a, shamt, sh and carry_in are sampled only at accept; later changes have no effect.
- in_valid is ignored outside IDLE.

## Timing
- Reset values (asynchronous): state IDLE, in_ready 1, out_valid 0, busy 0, result 0, carry_out 0, cnt 0.
- Latency is counted from the accept edge to the first cycle with out_valid high: 1 cycle if cnt = 0, otherwise 1 + ceil(cnt/STEP) cycles.
- In DONE, result and carry_out are held stable until the out_ready edge, whatever the duration of backpressure.
- in_ready and out_valid are decoded from state only. in_ready is 0 in the cycle DONE is left, so back-to-back operations have at least one IDLE cycle between them.
- Reset asserted mid-operation aborts it. No out_valid is produced for the aborted request. in_ready is high as soon as reset is asserted.

## Test plan
- STEP=1, LSL, a=0x00000001, shamt=4, carry_in=1 → result 0x00000010, carry_out 0, out_valid 5 cycles after accept.
- STEP=1, LSR, a=0x80000000: shamt=32 → result 0, carry_out 1. Repeat with shamt=33 → result 0, carry_out 0.
- STEP=8, ASR, a=0x80000000, shamt=200 → result 0xFFFFFFFF, carry_out 1, latency 5.
- STEP=4, ROR, a=0x000000F1, shamt=4 → result 0x1000000F, carry_out 0. ROR with shamt=64, a=0x80000001 → result 0x80000001, carry_out 1. Any mode with shamt=0 and carry_in=1 → result = a, carry_out 1, latency 1.
- Backpressure: hold out_ready=0 for 3 cycles while in_valid=1 → result and carry stable, in_ready 0, no second accept. The second request is accepted only after the IDLE cycle.
- Assert reset during SHIFT (STEP=1, shamt=20) → out_valid never asserts, in_ready 1 immediately. The next request, LSL 0x3 by 1, returns 0x6.

Source files
------------

// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit with ARM register-specified shift semantics (LSL/LSR/ASR/ROR)
// and shifter carry-out. Valid/ready on both sides; STEP bits are shifted per cycle.
module seq_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 8,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         sh,
  input  logic               carry_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               carry_out,
  output logic               busy
);

  localparam int CNT_W = $clog2(WIDTH + 2);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam logic [CNT_W-1:0]   ONE_C      = CNT_W'(1);
  localparam logic [CNT_W-1:0]   STEP_C     = CNT_W'(STEP);
  localparam logic [CNT_W-1:0]   WIDTH_C    = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0]   WIDTH_P1_C = CNT_W'(WIDTH + 1);
  localparam logic [SHAMT_W-1:0] SH_WIDTH   = SHAMT_W'(WIDTH);
  localparam logic [SHAMT_W-1:0] SH_WIDTH_P1 = SHAMT_W'(WIDTH + 1);
  localparam logic [WIDTH-1:0]   BIT0       = WIDTH'(1);

  logic [1:0]         state_q, state_d;
  logic [1:0]         mode_q,  mode_d;
  logic [WIDTH-1:0]   work_q,  work_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;

  logic [SHAMT_W-1:0] ror_m;
  logic [CNT_W-1:0]   load_cnt;
  logic [CNT_W-1:0]   step_amt;
  logic               carry_left;
  logic               carry_right;

  // The count clamps make the ARM edge cases (by WIDTH, beyond WIDTH, ROR by multiples) fall out naturally.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    load_cnt = '0;
    ror_m    = shamt % SH_WIDTH;
    if (shamt != '0) begin
      case (sh)
        SH_LSL, SH_LSR: load_cnt = (shamt > SH_WIDTH_P1) ? WIDTH_P1_C : CNT_W'(shamt);
        SH_ASR:         load_cnt = (shamt >= SH_WIDTH)   ? WIDTH_C    : CNT_W'(shamt);
        default:        load_cnt = (ror_m == '0)         ? WIDTH_C    : CNT_W'(ror_m);
      endcase
    end
  end

  always_comb begin
    step_amt    = (cnt_q < STEP_C) ? cnt_q : STEP_C;
    carry_left  = |(work_q & (BIT0 << (WIDTH_C - step_amt)));
    carry_right = |(work_q & (BIT0 << (step_amt - ONE_C)));
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    work_d  = work_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          work_d  = a;
          carry_d = carry_in;
          mode_d  = sh;
          cnt_d   = load_cnt;
          state_d = (load_cnt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        case (mode_q)
          SH_LSL: begin
            work_d  = work_q << step_amt;
            carry_d = carry_left;
          end
          SH_LSR: begin
            work_d  = work_q >> step_amt;
            carry_d = carry_right;
          end
          SH_ASR: begin
            work_d  = $signed(work_q) >>> step_amt;
            carry_d = carry_right;
          end
          default: begin
            work_d  = (work_q >> step_amt) | (work_q << (WIDTH_C - step_amt));
            carry_d = carry_right;
          end
        endcase
        cnt_d = cnt_q - step_amt;
        if (cnt_q == step_amt) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mode_q  <= SH_LSL;
      work_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      mode_q  <= mode_d;
      work_q  <= work_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign result    = work_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: three instances (STEP 1, 8, 4) share data inputs,
// each has its own in_valid; expected values are hand-computed.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  vld;
  logic [31:0] a;
  logic [7:0]  shamt;
  logic [1:0]  sh;
  logic        carry_in;
  logic        out_ready;

  logic [2:0]        rdy, ov, bz, co;
  logic [2:0][31:0]  res;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(32), .SHAMT_W(8), .STEP(1)) u_s1 (
    .clk(clk), .reset(rst), .in_valid(vld[0]), .in_ready(rdy[0]), .a(a), .shamt(shamt),
    .sh(sh), .carry_in(carry_in), .out_valid(ov[0]), .out_ready(out_ready),
    .result(res[0]), .carry_out(co[0]), .busy(bz[0]));

  seq_shifter #(.WIDTH(32), .SHAMT_W(8), .STEP(8)) u_s8 (
    .clk(clk), .reset(rst), .in_valid(vld[1]), .in_ready(rdy[1]), .a(a), .shamt(shamt),
    .sh(sh), .carry_in(carry_in), .out_valid(ov[1]), .out_ready(out_ready),
    .result(res[1]), .carry_out(co[1]), .busy(bz[1]));

  seq_shifter #(.WIDTH(32), .SHAMT_W(8), .STEP(4)) u_s4 (
    .clk(clk), .reset(rst), .in_valid(vld[2]), .in_ready(rdy[2]), .a(a), .shamt(shamt),
    .sh(sh), .carry_in(carry_in), .out_valid(ov[2]), .out_ready(out_ready),
    .result(res[2]), .carry_out(co[2]), .busy(bz[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request to instance i for a single edge, then scramble the data inputs.
  task automatic start(input int i, input logic [31:0] av, input logic [7:0] sv,
                       input logic [1:0] shv, input logic ci);
    a = av; shamt = sv; sh = shv; carry_in = ci;
    vld[i] = 1'b1;
    step();
    vld[i] = 1'b0;
    a = 32'hDEAD_BEEF; shamt = 8'd7; sh = ~shv; carry_in = ~ci;
  endtask

  task automatic wait_done(input int i, output int lat);
    lat = 1;
    while (ov[i] !== 1'b1 && lat < 100) begin
      step();
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input int i, input logic [31:0] av, input logic [7:0] sv,
                        input logic [1:0] shv, input logic ci, input logic [31:0] exp_res,
                        input logic exp_co, input int exp_lat);
    int lat;
    start(i, av, sv, shv, ci);
    wait_done(i, lat);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, res[i], exp_res);
    check({tag, " carry"}, 32'(co[i]), 32'(exp_co));
    release_result();
  endtask

  initial begin
    int lat;
    bit saw_valid;
    rst = 1'b1; vld = '0; a = '0; shamt = '0; sh = '0; carry_in = 1'b0; out_ready = 1'b0;
    step();
    check("reset in_ready", 32'(rdy[0]), 32'd1);
    check("reset out_valid", 32'(ov[0]), 32'd0);
    check("reset busy", 32'(bz[0]), 32'd0);
    check("reset result", res[0], 32'h0);
    check("reset carry", 32'(co[0]), 32'd0);
    rst = 1'b0;
    step();

    // LSL 1 by 4, STEP=1; busy/in_ready sampled mid-shift.
    start(0, 32'h0000_0001, 8'd4, 2'b00, 1'b1);
    check("lsl busy", 32'(bz[0]), 32'd1);
    check("lsl in_ready low", 32'(rdy[0]), 32'd0);
    wait_done(0, lat);
    check("lsl latency", 32'(lat), 32'd5);
    check("lsl result", res[0], 32'h0000_0010);
    check("lsl carry", 32'(co[0]), 32'd0);
    release_result();
    step();

    run_op("lsr32", 0, 32'h8000_0000, 8'd32, 2'b01, 1'b0, 32'h0, 1'b1, 33);
    step();
    run_op("lsr33", 0, 32'h8000_0000, 8'd33, 2'b01, 1'b1, 32'h0, 1'b0, 34);
    step();
    run_op("asr200", 1, 32'h8000_0000, 8'd200, 2'b10, 1'b0, 32'hFFFF_FFFF, 1'b1, 5);
    step();
    run_op("ror4", 2, 32'h0000_00F1, 8'd4, 2'b11, 1'b1, 32'h1000_000F, 1'b0, 2);
    step();
    run_op("ror64", 2, 32'h8000_0001, 8'd64, 2'b11, 1'b0, 32'h8000_0001, 1'b1, 9);
    step();
    run_op("asr0", 1, 32'h1234_5678, 8'd0, 2'b10, 1'b1, 32'h1234_5678, 1'b1, 1);
    step();
    run_op("lsl0", 2, 32'hCAFE_F00D, 8'd0, 2'b00, 1'b1, 32'hCAFE_F00D, 1'b1, 1);
    step();
    run_op("lsl1 s8 carry", 1, 32'h8000_0003, 8'd1, 2'b00, 1'b0, 32'h0000_0006, 1'b1, 2);
    step();

    // Backpressure: in_valid held high throughout; second request must wait for an IDLE cycle.
    a = 32'h0000_00F0; shamt = 8'd2; sh = 2'b00; carry_in = 1'b0;
    vld[0] = 1'b1;
    step();
    a = 32'h0000_0005; shamt = 8'd1; sh = 2'b00; carry_in = 1'b1;
    wait_done(0, lat);
    check("bp latency", 32'(lat), 32'd3);
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp held result", res[0], 32'h0000_03C0);
      check("bp held carry", 32'(co[0]), 32'd0);
      check("bp in_ready low", 32'(rdy[0]), 32'd0);
      check("bp out_valid held", 32'(ov[0]), 32'd1);
    end
    release_result();
    check("bp idle in_ready", 32'(rdy[0]), 32'd1);
    check("bp idle out_valid", 32'(ov[0]), 32'd0);
    step();
    vld[0] = 1'b0;
    check("bp second accepted", 32'(bz[0]), 32'd1);
    wait_done(0, lat);
    check("bp second latency", 32'(lat), 32'd2);
    check("bp second result", res[0], 32'h0000_000A);
    check("bp second carry", 32'(co[0]), 32'd0);
    release_result();
    step();

    // Reset in the middle of a long shift aborts it.
    start(0, 32'h0000_FFFF, 8'd20, 2'b01, 1'b0);
    repeat (5) step();
    rst = 1'b1;
    #1;
    check("abort in_ready", 32'(rdy[0]), 32'd1);
    check("abort out_valid", 32'(ov[0]), 32'd0);
    step();
    #2;
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (ov[0] === 1'b1) saw_valid = 1'b1;
    end
    check("abort no out_valid", 32'(saw_valid), 32'd0);
    run_op("post-reset lsl", 0, 32'h0000_0003, 8'd1, 2'b00, 1'b0, 32'h0000_0006, 1'b0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
